// File: rtl/fetch_prefetch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_prefetch_queue_pkg
//  Purpose  : Shared constants, FSM state encoding and the RVC length helper
//             for the halfword prefetch queue.
//  Contents : XLEN, ILEN16, fq_state_e, is_rvc()
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_prefetch_queue_pkg;

   localparam int XLEN   = 32;
   localparam int ILEN16 = 16;

   typedef enum logic [1:0] {
      FQ_IDLE = 2'd0,
      FQ_REQ  = 2'd1,
      FQ_WAIT = 2'd2,
      FQ_DROP = 2'd3
   } fq_state_e;

   // A halfword starts a compressed instruction unless its two LSBs are 11.
   function automatic logic is_rvc(input logic [ILEN16-1:0] hw);
      return (hw & 16'h0003) != 16'h0003;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_prefetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_prefetch_queue_if
//  Purpose  : Bundles the redirect, instruction-memory and decode handshakes
//             of the fetch front-end.
//  Modports : master - fetch unit side (drives mem request and decode output)
//             slave  - environment side (memory, branch unit, decode)
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_prefetch_queue_if #(
   parameter int XLEN = fetch_prefetch_queue_pkg::XLEN
);
   logic            redirect_i;
   logic [XLEN-1:0] redirect_pc_i;
   logic            mem_req_o;
   logic [XLEN-1:0] mem_addr_o;
   logic            mem_gnt_i;
   logic            mem_rvalid_i;
   logic [31:0]     mem_rdata_i;
   logic            instr_valid_o;
   logic            instr_ready_i;
   logic [31:0]     instr_o;
   logic            instr_c_o;
   logic [XLEN-1:0] pc_o;

   modport master (
      input  redirect_i, redirect_pc_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
             instr_ready_i,
      output mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_c_o, pc_o
   );

   modport slave (
      output redirect_i, redirect_pc_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
             instr_ready_i,
      input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_c_o, pc_o
   );
endinterface
`default_nettype wire

// File: rtl/fetch_prefetch_queue_hw_ring_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : hw_ring_buffer
//  Purpose  : Circular buffer of 16-bit halfwords, up to two pushed and two
//             popped per cycle. clear empties it and overrides push/pop.
//  Ports    : clk, rst_n (async, active-low), clear,
//             push_n[1:0] (0..2, push_hw0 first then push_hw1),
//             pop_n[1:0]  (0..2), count (occupancy),
//             head0/head1 (oldest and second-oldest halfword)
//  Revision : 1.0 - initial release
// ============================================================================
module hw_ring_buffer
   import fetch_prefetch_queue_pkg::*;
#(
   parameter int DEPTH_HW = 8
) (
   input  wire logic                          clk,
   input  wire logic                          rst_n,
   input  wire logic                          clear,
   input  wire logic [1:0]                    push_n,
   input  wire logic [ILEN16-1:0]             push_hw0,
   input  wire logic [ILEN16-1:0]             push_hw1,
   input  wire logic [1:0]                    pop_n,
   output logic      [$clog2(DEPTH_HW):0]     count,
   output logic      [ILEN16-1:0]             head0,
   output logic      [ILEN16-1:0]             head1
);
   localparam int c_PW = $clog2(DEPTH_HW);
   localparam int c_CW = c_PW + 1;

   logic [ILEN16-1:0] r_mem [DEPTH_HW];
   logic [c_PW-1:0]   r_wr;
   logic [c_PW-1:0]   r_rd;
   logic [c_CW-1:0]   r_count;
   logic [c_PW-1:0]   w_wr1;
   logic [c_PW-1:0]   w_rd1;

   // Power-of-two depth: pointer arithmetic wraps for free.
   assign w_wr1 = r_wr + c_PW'(1);
   assign w_rd1 = r_rd + c_PW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else if (clear) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         r_wr    <= r_wr + c_PW'(push_n);
         r_rd    <= r_rd + c_PW'(pop_n);
         r_count <= r_count + c_CW'(push_n) - c_CW'(pop_n);
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (!clear) begin
         if (push_n != 2'd0) r_mem[r_wr]  <= push_hw0;
         if (push_n == 2'd2) r_mem[w_wr1] <= push_hw1;
      end
   end

   assign count = r_count;
   assign head0 = r_mem[r_rd];
   assign head1 = r_mem[w_rd1];

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_prefetch_queue
//  Purpose  : Fetch front-end. Requests 32-bit words from instruction memory,
//             queues them as halfwords and hands realigned 16/32-bit
//             instructions to decode. Handles branch redirect (with drop of
//             an outstanding response) and decode back-pressure.
//  Ports    : clk, rst_n (async, active-low),
//             bus (fetch_prefetch_queue_if.master): redirect, memory
//             request/response, decode valid/ready/instr/pc.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_prefetch_queue
   import fetch_prefetch_queue_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH_HW = 8,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   fetch_prefetch_queue_if.master bus
);
   localparam int c_CW = $clog2(DEPTH_HW) + 1;

   fq_state_e         r_state;
   logic [XLEN-1:0]   r_fetch_pc;
   logic [XLEN-1:0]   r_out_pc;
   logic              r_skip_lo;
   logic              r_run;

   logic [c_CW-1:0]   w_count;
   logic [c_CW-1:0]   w_count_next;
   logic [ILEN16-1:0] w_head0;
   logic [ILEN16-1:0] w_head1;
   logic [ILEN16-1:0] w_push_hw0;
   logic              w_is_c;
   logic              w_valid;
   logic              w_fire;
   logic              w_rsp;
   logic              w_space_ok;
   logic [1:0]        w_push_n;
   logic [1:0]        w_pop_n;

   always_comb begin
      w_is_c       = is_rvc(w_head0);
      // A 32-bit head whose upper half is not yet fetched stays invalid.
      w_valid      = w_is_c ? (w_count >= c_CW'(1)) : (w_count >= c_CW'(2));
      w_fire       = w_valid & bus.instr_ready_i;
      w_pop_n      = w_fire ? (w_is_c ? 2'd1 : 2'd2) : 2'd0;
      w_rsp        = (r_state == FQ_WAIT) & bus.mem_rvalid_i;
      w_push_n     = w_rsp ? (r_skip_lo ? 2'd1 : 2'd2) : 2'd0;
      w_push_hw0   = r_skip_lo ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
      w_count_next = w_count + c_CW'(w_push_n) - c_CW'(w_pop_n);
      // Two free slots reserved for the word about to be requested.
      w_space_ok   = w_count_next <= c_CW'(DEPTH_HW - 2);
   end

   hw_ring_buffer #(
      .DEPTH_HW (DEPTH_HW)
   ) u_ring (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (bus.redirect_i),
      .push_n   (w_push_n),
      .push_hw0 (w_push_hw0),
      .push_hw1 (bus.mem_rdata_i[31:16]),
      .pop_n    (w_pop_n),
      .count    (w_count),
      .head0    (w_head0),
      .head1    (w_head1)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= FQ_IDLE;
         r_fetch_pc <= RESET_PC;
         r_out_pc   <= RESET_PC;
         r_skip_lo  <= 1'b0;
         r_run      <= 1'b0;
      end else begin
         // One quiet cycle after reset release before the first request.
         r_run <= 1'b1;
         if (bus.redirect_i) begin
            r_fetch_pc <= bus.redirect_pc_i & ~XLEN'(3);
            r_out_pc   <= bus.redirect_pc_i & ~XLEN'(1);
            r_skip_lo  <= bus.redirect_pc_i[1];
            case (r_state)
               // A grant in the redirect cycle leaves a stale response in flight.
               FQ_REQ:           r_state <= bus.mem_gnt_i ? FQ_DROP : FQ_REQ;
               // A response landing in the redirect cycle is simply discarded.
               FQ_WAIT, FQ_DROP: r_state <= bus.mem_rvalid_i ? FQ_REQ : FQ_DROP;
               default:          r_state <= FQ_REQ;
            endcase
         end else begin
            if (w_fire) r_out_pc <= r_out_pc + (w_is_c ? XLEN'(2) : XLEN'(4));
            case (r_state)
               FQ_IDLE: if (r_run && w_space_ok) r_state <= FQ_REQ;
               FQ_REQ: begin
                  if (bus.mem_gnt_i) begin
                     r_fetch_pc <= r_fetch_pc + XLEN'(4);
                     r_state    <= FQ_WAIT;
                  end
               end
               FQ_WAIT: begin
                  if (bus.mem_rvalid_i) begin
                     r_skip_lo <= 1'b0;
                     r_state   <= w_space_ok ? FQ_REQ : FQ_IDLE;
                  end
               end
               FQ_DROP: begin
                  if (bus.mem_rvalid_i) r_state <= w_space_ok ? FQ_REQ : FQ_IDLE;
               end
               default: r_state <= FQ_IDLE;
            endcase
         end
      end
   end

   assign bus.mem_req_o     = (r_state == FQ_REQ);
   assign bus.mem_addr_o    = r_fetch_pc;
   assign bus.instr_valid_o = w_valid;
   assign bus.instr_o       = w_is_c ? {16'h0000, w_head0} : {w_head1, w_head0};
   assign bus.instr_c_o     = w_is_c;
   assign bus.pc_o          = r_out_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_prefetch_queue
//  Purpose  : Self-checking bench for fetch_prefetch_queue. A memory model
//             serves words from an image; a reference model walks the image
//             instruction by instruction from the architectural pc and
//             predicts every instruction handed to decode.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_queue;

   logic clk;
   logic rst_n;

   fetch_prefetch_queue_if #(.XLEN(32)) bus ();

   fetch_prefetch_queue #(
      .XLEN     (32),
      .DEPTH_HW (8),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_err;
   int n_pops;

   logic [31:0] img [256];

   // stimulus knobs
   int          p_ready;
   int          p_gnt;
   int          max_lat;
   int          p_redir;   // per mille
   logic        force_redir;
   logic [31:0] force_tgt;

   // memory model state
   logic        pend;
   logic        pend_stale;
   logic [31:0] pend_addr;
   int          lat;

   // reference model state
   logic [31:0] m_pc;
   logic [31:0] exp_fetch;
   logic        prev_hold;
   logic [31:0] prev_instr;
   logic [31:0] prev_pc;
   logic        prev_c;
   logic        obs_req;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] hw_at(input logic [31:0] a);
      logic [31:0] w;
      w = img[a[9:2]];
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   task automatic drive_idle();
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = '0;
      bus.mem_gnt_i     = 1'b0;
      bus.mem_rvalid_i  = 1'b0;
      bus.mem_rdata_i   = '0;
      bus.instr_ready_i = 1'b0;
   endtask

   task automatic model_reset();
      pend       = 1'b0;
      pend_stale = 1'b0;
      lat        = 0;
      m_pc       = 32'h0;
      exp_fetch  = 32'h0;
      prev_hold  = 1'b0;
   endtask

   // Reset, optionally with a stale response showing up right after release.
   task automatic apply_reset(input logic late_rsp);
      @(negedge clk);
      rst_n = 1'b0;
      drive_idle();
      repeat (2) begin
         @(negedge clk);
         check_val("rst_req", {31'b0, bus.mem_req_o}, 32'd0);
         check_val("rst_valid", {31'b0, bus.instr_valid_o}, 32'd0);
      end
      rst_n = 1'b1;
      if (late_rsp) begin
         bus.mem_rvalid_i = 1'b1;
         bus.mem_rdata_i  = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      check_val("post_rst_req", {31'b0, bus.mem_req_o}, 32'd0);
      check_val("post_rst_valid", {31'b0, bus.instr_valid_o}, 32'd0);
      drive_idle();
      model_reset();
   endtask

   task automatic step();
      logic        v, co, req, redir, rdy, g, rv, had_pend, ec;
      logic [31:0] ins, pco, addr, tgt, rd, ei;
      logic [15:0] h0;
      @(negedge clk);
      v    = bus.instr_valid_o;
      co   = bus.instr_c_o;
      ins  = bus.instr_o;
      pco  = bus.pc_o;
      req  = bus.mem_req_o;
      addr = bus.mem_addr_o;
      obs_req = req;

      if (prev_hold) begin
         check_val("hold_valid", {31'b0, v}, 32'd1);
         check_val("hold_instr", ins, prev_instr);
         check_val("hold_pc", pco, prev_pc);
         check_val("hold_c", {31'b0, co}, {31'b0, prev_c});
      end

      redir = force_redir || (p_redir > 0 && int'($urandom_range(0, 999)) < p_redir);
      tgt   = force_redir ? force_tgt : 32'($urandom_range(0, 1023));
      rdy   = int'($urandom_range(0, 99)) < p_ready;
      g     = int'($urandom_range(0, 99)) < p_gnt;
      rv    = 1'b0;
      rd    = $urandom();

      had_pend = pend;
      if (pend) begin
         if (lat == 0) begin
            rv   = 1'b1;
            rd   = (pend_stale || redir) ? 32'hDEAD_BEEF : img[pend_addr[9:2]];
            pend = 1'b0;
         end else begin
            lat--;
         end
      end
      if (had_pend) check_val("req_while_pending", {31'b0, req}, 32'd0);

      if (req && g) begin
         check_val("fetch_addr", addr, exp_fetch);
         pend       = 1'b1;
         pend_addr  = addr;
         lat        = int'($urandom_range(0, max_lat));
         pend_stale = redir;
         exp_fetch  = exp_fetch + 32'd4;
      end
      if (redir) begin
         exp_fetch = tgt & ~32'h3;
         if (pend) pend_stale = 1'b1;
      end

      if (v && rdy) begin
         h0 = hw_at(m_pc);
         ec = (h0[1:0] != 2'b11);
         ei = ec ? {16'h0, h0} : {hw_at(m_pc + 32'd2), h0};
         check_val("pop_pc", pco, m_pc);
         check_val("pop_instr", ins, ei);
         check_val("pop_c", {31'b0, co}, {31'b0, ec});
         m_pc = m_pc + (ec ? 32'd2 : 32'd4);
         n_pops++;
      end
      if (redir) m_pc = tgt & ~32'h1;

      prev_hold  = v && !rdy && !redir;
      prev_instr = ins;
      prev_pc    = pco;
      prev_c     = co;

      bus.redirect_i    = redir;
      bus.redirect_pc_i = tgt;
      bus.instr_ready_i = rdy;
      bus.mem_gnt_i     = g;
      bus.mem_rvalid_i  = rv;
      bus.mem_rdata_i   = rd;
   endtask

   task automatic redirect_to(input logic [31:0] t);
      force_redir = 1'b1;
      force_tgt   = t;
      step();
      force_redir = 1'b0;
   endtask

   task automatic wait_pending();
      for (int i = 0; i < 100 && !pend; i++) step();
      check_val("wait_pending", {31'b0, pend}, 32'd1);
   endtask

   initial begin
      logic [15:0] a, b;
      n_cmp = 0;
      n_err = 0;
      n_pops = 0;
      force_redir = 1'b0;
      force_tgt   = '0;
      obs_req     = 1'b0;
      rst_n       = 1'b0;
      drive_idle();
      model_reset();

      // Random image mixing compressed and 32-bit parcels, plus directed words.
      for (int i = 0; i < 256; i++) begin
         a = 16'($urandom());
         b = 16'($urandom());
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b11;
         if ($urandom_range(0, 1) == 1) b[1:0] = 2'b11;
         img[i] = {b, a};
      end
      for (int i = 0; i < 4; i++) img[i] = 32'h0000_0013;
      img[16] = 32'h0001_4501;   // 0x40
      img[32] = 32'h0013_4501;   // 0x80
      img[33] = 32'h1234_0093;   // 0x84
      img[64] = 32'h0001_4501;   // 0x100

      apply_reset(1'b0);

      // Plain 32-bit stream from reset, full throughput.
      p_ready = 100; p_gnt = 100; max_lat = 0; p_redir = 0;
      repeat (14) step();
      check_val("t1_pops", {31'b0, n_pops >= 4}, 32'd1);

      // Compressed pair, then compressed + straddling 32-bit.
      redirect_to(32'h40);
      repeat (10) step();
      redirect_to(32'h80);
      p_ready = 50; p_gnt = 50; max_lat = 2;
      repeat (16) step();

      // Redirect to an odd halfword while a response is outstanding.
      wait_pending();
      redirect_to(32'h102);
      repeat (16) step();

      // Decode stall: queue fills and fetching must stop, then resumes.
      p_ready = 0; p_gnt = 100; max_lat = 0;
      repeat (20) step();
      check_val("stall_no_req", {31'b0, obs_req}, 32'd0);
      p_ready = 100;
      repeat (20) step();

      // Reset while waiting for memory, with a late response after release.
      p_gnt = 100; max_lat = 3;
      wait_pending();
      apply_reset(1'b1);
      repeat (12) step();

      // Randomised traffic with redirects and back-pressure.
      n_pops = 0;
      p_ready = 70; p_gnt = 60; max_lat = 3; p_redir = 20;
      repeat (3000) step();
      check_val("random_progress", {31'b0, n_pops >= 300}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
